// File: rtl/regfile_op_sequencer.sv
// regfile_op_sequencer: multi-cycle initiator for the 8x16 register file port.
// Accepts one register-transfer command at a time, reads up to two operands
// through the single combinational read port, evaluates, and writes back.
module regfile_op_sequencer #(
  parameter int DW   = 16,
  parameter int IMMW = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [2:0]      cmd_op,
  input  logic [2:0]      cmd_rd,
  input  logic [2:0]      cmd_rn,
  input  logic [2:0]      cmd_rm,
  input  logic [IMMW-1:0] cmd_imm,
  output logic [2:0]      readnum,
  input  logic [DW-1:0]   data_out,
  output logic [2:0]      writenum,
  output logic            write,
  output logic [DW-1:0]   data_in,
  output logic [DW-1:0]   result,
  output logic            flag_z,
  output logic            flag_n,
  output logic            flag_v,
  output logic            done,
  output logic            err
);

  typedef enum logic [2:0] {
    OP_MOVI = 3'd0,
    OP_MOV  = 3'd1,
    OP_ADD  = 3'd2,
    OP_SUB  = 3'd3,
    OP_AND  = 3'd4,
    OP_MVN  = 3'd5,
    OP_CMP  = 3'd6,
    OP_ILL  = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD_A = 3'd1,
    S_RD_B = 3'd2,
    S_EXEC = 3'd3,
    S_WB   = 3'd4,
    S_DONE = 3'd5
  } state_e;

  state_e               state;
  op_e                  op_q;
  logic [2:0]           rd_q;
  logic [2:0]           rm_q;
  logic [IMMW-1:0]      imm_q;
  logic signed [DW-1:0] opa_q;
  logic signed [DW-1:0] opb_q;
  logic signed [DW-1:0] sum_val;
  logic signed [DW-1:0] dif_val;
  logic signed [DW-1:0] alu_val;
  logic                 alu_v;
  logic                 sets_flags;

  // Sign-extend the immediate to the datapath width.
  function automatic logic signed [DW-1:0] sext_imm(input logic [IMMW-1:0] imm);
    return {{(DW-IMMW){imm[IMMW-1]}}, imm};
  endfunction

  // Signed overflow of a+b: same-sign operands producing a different-sign sum.
  function automatic logic add_ovf(input logic signed [DW-1:0] a,
                                   input logic signed [DW-1:0] b,
                                   input logic signed [DW-1:0] s);
    return (a[DW-1] == b[DW-1]) && (s[DW-1] != a[DW-1]);
  endfunction

  // Signed overflow of a-b: differing-sign operands whose difference flips sign from a.
  function automatic logic sub_ovf(input logic signed [DW-1:0] a,
                                   input logic signed [DW-1:0] b,
                                   input logic signed [DW-1:0] s);
    return (a[DW-1] != b[DW-1]) && (s[DW-1] != a[DW-1]);
  endfunction

  // Ready only in IDLE and never while reset is held.
  assign cmd_ready = reset_n && (state == S_IDLE);

  // The write port always presents the latest computed value.
  assign data_in = result;

  assign sum_val    = opa_q + opb_q;
  assign dif_val    = opa_q - opb_q;
  assign sets_flags = (op_q == OP_ADD) || (op_q == OP_SUB) || (op_q == OP_CMP);

  // ALU: evaluates the captured opcode on the captured operands.
  always_comb begin
    alu_val = result;
    alu_v   = flag_v;
    case (op_q)
      OP_MOVI: alu_val = sext_imm(imm_q);
      OP_MOV:  alu_val = opb_q;
      OP_ADD: begin
        alu_val = sum_val;
        alu_v   = add_ovf(opa_q, opb_q, sum_val);
      end
      OP_SUB, OP_CMP: begin
        alu_val = dif_val;
        alu_v   = sub_ovf(opa_q, opb_q, dif_val);
      end
      OP_AND:  alu_val = opa_q & opb_q;
      OP_MVN:  alu_val = ~opb_q;
      default: alu_val = result;
    endcase
  end

  // Command FSM with registered register-file controls; reset aborts at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      op_q     <= OP_MOVI;
      rd_q     <= '0;
      rm_q     <= '0;
      imm_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      readnum  <= '0;
      writenum <= '0;
      write    <= 1'b0;
      result   <= '0;
      flag_z   <= 1'b0;
      flag_n   <= 1'b0;
      flag_v   <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      done    <= 1'b0;
      err     <= 1'b0;
      write   <= 1'b0;
      readnum <= '0;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            op_q  <= op_e'(cmd_op);
            rd_q  <= cmd_rd;
            rm_q  <= cmd_rm;
            imm_q <= cmd_imm;
            case (op_e'(cmd_op))
              OP_ADD, OP_SUB, OP_AND, OP_CMP: begin
                state   <= S_RD_A;
                readnum <= cmd_rn;
              end
              OP_MOV, OP_MVN: begin
                state   <= S_RD_B;
                readnum <= cmd_rm;
              end
              OP_MOVI: state <= S_EXEC;
              default: begin
                state <= S_DONE;
                done  <= 1'b1;
                err   <= 1'b1;
              end
            endcase
          end
        end
        S_RD_A: begin
          opa_q   <= data_out;
          readnum <= rm_q;
          state   <= S_RD_B;
        end
        S_RD_B: begin
          opb_q <= data_out;
          state <= S_EXEC;
        end
        S_EXEC: begin
          result <= alu_val;
          if (sets_flags) begin
            flag_z <= (alu_val == '0);
            flag_n <= alu_val[DW-1];
            flag_v <= alu_v;
          end
          if (op_q == OP_CMP) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            state    <= S_WB;
            write    <= 1'b1;
            writenum <= rd_q;
          end
        end
        S_WB: begin
          state <= S_DONE;
          done  <= 1'b1;
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
